apb_master: RTL

- APB initiator that turns single-beat read/write commands from a local requester into APB SETUP/ACCESS transfers to up to NUM_SLAVES peripherals.
- Decodes the slave from the address and drives one select line per slave.
- Returns read data or error on a one-cycle response strobe.
- Bounds every transfer with a wait-state timeout so that a hung slave cannot stall the bus.

---
 rtl/apb_pkg.sv | 29 ++
 rtl/apb_addr_decode.sv | 34 +++
 rtl/apb_master.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB initiator and its address decoder:
// FSM state encoding, default bus widths and response error codes.
package apb_pkg;

    // Default bus widths
    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_SETUP_ENC  = 2'd1;
    localparam logic [1:0] ST_ACCESS_ENC = 2'd2;
    localparam logic [1:0] ST_RESP_ENC   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_SETUP  = ST_SETUP_ENC,
        ST_ACCESS = ST_ACCESS_ENC,
        ST_RESP   = ST_RESP_ENC
    } apb_state_e;

    // Response codes, kept for a richer error port than the single err bit
    typedef enum logic [1:0] {
        RSP_OK          = 2'd0,
        RSP_DECODE_ERR  = 2'd1,
        RSP_TIMEOUT_ERR = 2'd2
    } apb_rsp_code_e;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational region decoder: address >> REGION_SHIFT selects a slave.
// Produces the binary index, a one-hot select and an out-of-range flag.
// Also intended for reuse by the APB interconnect.
module apb_addr_decode #(
    parameter int ADDR_WIDTH   = 32,
    parameter int NUM_SLAVES   = 2,
    parameter int REGION_SHIFT = 8,
    parameter int IDX_W        = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [IDX_W-1:0]      idx,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  dec_err
);

    logic [ADDR_WIDTH-1:0] region_s;

    assign region_s = addr >> REGION_SHIFT;

    // Index, one-hot select and range check for the addressed region
    always_comb begin
        idx     = region_s[IDX_W-1:0];
        dec_err = (region_s >= ADDR_WIDTH'(NUM_SLAVES));
        sel     = {NUM_SLAVES{1'b0}};
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (region_s == ADDR_WIDTH'(k)) begin
                sel[k] = 1'b1;
            end else begin
                sel[k] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB initiator: converts single-beat local read/write commands into APB
// SETUP/ACCESS transfers, with address decode and a wait-state timeout.
// All outputs are registered; cmd_ready is registered from the next state.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int NUM_SLAVES     = 2,
    parameter int REGION_SHIFT   = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             pclk_i,
    input  logic                             prst_i,
    input  logic                             cmd_valid_i,
    output logic                             cmd_ready_o,
    input  logic                             cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]            cmd_wdata_i,
    output logic                             rsp_valid_o,
    output logic [DATA_WIDTH-1:0]            rsp_rdata_o,
    output logic                             rsp_err_o,
    output logic [ADDR_WIDTH-1:0]            paddr_o,
    output logic [NUM_SLAVES-1:0]            psel_o,
    output logic                             penable_o,
    output logic                             pwrite_o,
    output logic [DATA_WIDTH-1:0]            pwdata_o,
    input  logic [NUM_SLAVES-1:0]            pready_i,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata_i
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    apb_state_e state_r, state_nxt_s;

    logic                  cmd_ready_r,   cmd_ready_nxt_s;
    logic                  rsp_valid_r,   rsp_valid_nxt_s;
    logic [DATA_WIDTH-1:0] rsp_rdata_r,   rsp_rdata_nxt_s;
    logic                  rsp_err_r,     rsp_err_nxt_s;
    logic [ADDR_WIDTH-1:0] paddr_r,       paddr_nxt_s;
    logic [NUM_SLAVES-1:0] psel_r,        psel_nxt_s;
    logic                  penable_r,     penable_nxt_s;
    logic                  pwrite_r,      pwrite_nxt_s;
    logic [DATA_WIDTH-1:0] pwdata_r,      pwdata_nxt_s;
    logic [IDX_W-1:0]      idx_r,         idx_nxt_s;
    logic [CNT_W-1:0]      cnt_r,         cnt_nxt_s;

    logic [IDX_W-1:0]      dec_idx_s;
    logic [NUM_SLAVES-1:0] dec_sel_s;
    logic                  dec_err_s;
    logic                  accept_s;
    logic                  sel_ready_s;
    logic [DATA_WIDTH-1:0] sel_rdata_s;
    logic [CNT_W-1:0]      cnt_inc_s;

    apb_addr_decode #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .NUM_SLAVES   (NUM_SLAVES),
        .REGION_SHIFT (REGION_SHIFT),
        .IDX_W        (IDX_W)
    ) u_decode (
        .addr    (cmd_addr_i),
        .idx     (dec_idx_s),
        .sel     (dec_sel_s),
        .dec_err (dec_err_s)
    );

    assign accept_s    = cmd_valid_i & cmd_ready_r;
    assign sel_ready_s = pready_i[idx_r];
    assign sel_rdata_s = prdata_i[idx_r*DATA_WIDTH +: DATA_WIDTH];
    assign cnt_inc_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state and next-output logic for the transfer FSM
    always_comb begin
        state_nxt_s     = state_r;
        rsp_valid_nxt_s = 1'b0;
        rsp_rdata_nxt_s = rsp_rdata_r;
        rsp_err_nxt_s   = rsp_err_r;
        paddr_nxt_s     = paddr_r;
        psel_nxt_s      = psel_r;
        penable_nxt_s   = penable_r;
        pwrite_nxt_s    = pwrite_r;
        pwdata_nxt_s    = pwdata_r;
        idx_nxt_s       = idx_r;
        cnt_nxt_s       = cnt_r;

        case (state_r)
            ST_IDLE: begin
                psel_nxt_s    = {NUM_SLAVES{1'b0}};
                penable_nxt_s = 1'b0;
                cnt_nxt_s     = {CNT_W{1'b0}};
                if (accept_s) begin
                    if (dec_err_s) begin
                        // Unmapped region: answer immediately, no bus cycle
                        state_nxt_s     = ST_RESP;
                        rsp_valid_nxt_s = 1'b1;
                        rsp_err_nxt_s   = 1'b1;
                        rsp_rdata_nxt_s = {DATA_WIDTH{1'b0}};
                    end else begin
                        state_nxt_s  = ST_SETUP;
                        paddr_nxt_s  = cmd_addr_i;
                        pwrite_nxt_s = cmd_write_i;
                        pwdata_nxt_s = cmd_write_i ? cmd_wdata_i : {DATA_WIDTH{1'b0}};
                        psel_nxt_s   = dec_sel_s;
                        idx_nxt_s    = dec_idx_s;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nxt_s   = ST_ACCESS;
                penable_nxt_s = 1'b1;
                cnt_nxt_s     = {CNT_W{1'b0}};
            end
            ST_ACCESS: begin
                if (sel_ready_s) begin
                    // Ready takes priority over a coincident timeout
                    state_nxt_s     = ST_RESP;
                    psel_nxt_s      = {NUM_SLAVES{1'b0}};
                    penable_nxt_s   = 1'b0;
                    rsp_valid_nxt_s = 1'b1;
                    rsp_err_nxt_s   = 1'b0;
                    rsp_rdata_nxt_s = pwrite_r ? {DATA_WIDTH{1'b0}} : sel_rdata_s;
                end else if (cnt_inc_s == CNT_LIMIT) begin
                    state_nxt_s     = ST_RESP;
                    psel_nxt_s      = {NUM_SLAVES{1'b0}};
                    penable_nxt_s   = 1'b0;
                    rsp_valid_nxt_s = 1'b1;
                    rsp_err_nxt_s   = 1'b1;
                    rsp_rdata_nxt_s = {DATA_WIDTH{1'b0}};
                    cnt_nxt_s       = cnt_inc_s;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            ST_RESP: begin
                state_nxt_s   = ST_IDLE;
                psel_nxt_s    = {NUM_SLAVES{1'b0}};
                penable_nxt_s = 1'b0;
                cnt_nxt_s     = {CNT_W{1'b0}};
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                psel_nxt_s    = {NUM_SLAVES{1'b0}};
                penable_nxt_s = 1'b0;
                cnt_nxt_s     = {CNT_W{1'b0}};
            end
        endcase

        cmd_ready_nxt_s = (state_nxt_s == ST_IDLE);
    end

    // FSM state register
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered outputs, captured command and wait-state counter
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            cmd_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
            paddr_r     <= {ADDR_WIDTH{1'b0}};
            psel_r      <= {NUM_SLAVES{1'b0}};
            penable_r   <= 1'b0;
            pwrite_r    <= 1'b0;
            pwdata_r    <= {DATA_WIDTH{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            cmd_ready_r <= cmd_ready_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_rdata_r <= rsp_rdata_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
            paddr_r     <= paddr_nxt_s;
            psel_r      <= psel_nxt_s;
            penable_r   <= penable_nxt_s;
            pwrite_r    <= pwrite_nxt_s;
            pwdata_r    <= pwdata_nxt_s;
            idx_r       <= idx_nxt_s;
            cnt_r       <= cnt_nxt_s;
        end
    end

    assign cmd_ready_o = cmd_ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rsp_rdata_r;
    assign rsp_err_o   = rsp_err_r;
    assign paddr_o     = paddr_r;
    assign psel_o      = psel_r;
    assign penable_o   = penable_r;
    assign pwrite_o    = pwrite_r;
    assign pwdata_o    = pwdata_r;

endmodule
